// File: rtl/duck_pkg.sv
// Shared types and defaults for the duck sprite sequencer: life states,
// animation frame codes and the flap-phase to frame mapping.
package duck_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_SHOT = 2'd2,
    ST_FALL = 2'd3
  } duck_state_t;

  typedef enum logic [2:0] {
    FR_FLAP0 = 3'd0,
    FR_FLAP1 = 3'd1,
    FR_FLAP2 = 3'd2,
    FR_SHOT  = 3'd3,
    FR_FALL  = 3'd4
  } frame_t;

  localparam int SPRITE_W_DEF = 20;
  localparam int SPRITE_H_DEF = 20;

  // Wing cycle is down-mid-up-mid, so phase 3 reuses the middle frame.
  function automatic frame_t flap_frame_of(input logic [1:0] phase);
    frame_t fr;
    case (phase)
      2'd0:    fr = FR_FLAP0;
      2'd1:    fr = FR_FLAP1;
      2'd2:    fr = FR_FLAP2;
      default: fr = FR_FLAP1;
    endcase
    return fr;
  endfunction

endpackage

// File: rtl/duck_fsm.sv
// Life-cycle FSM for one duck with its SHOT hold counter; maps the current
// state plus the shared flap frame onto the frame to draw.
module duck_fsm
  import duck_pkg::*;
#(
  parameter int SHOT_TICKS = 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_spawn,
  input  logic        i_shot,
  input  logic        i_landed,
  input  frame_t      i_flap_frame,
  output duck_state_t o_state,
  output frame_t      o_frame
);

  localparam int HW = (SHOT_TICKS > 1) ? $clog2(SHOT_TICKS) : 1;

  duck_state_t r_state;
  logic [HW-1:0] r_hold;

  // State transitions; the hold counter only advances while the duck is in SHOT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_spawn) r_state <= ST_FLY;
        end
        ST_FLY: begin
          if (i_shot) begin
            r_state <= ST_SHOT;
            r_hold  <= '0;
          end
        end
        ST_SHOT: begin
          if (i_frame_tick) begin
            if (r_hold == HW'(SHOT_TICKS - 1)) r_state <= ST_FALL;
            else                               r_hold  <= r_hold + HW'(1);
          end
        end
        ST_FALL: begin
          if (i_landed) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Frame follows the registered state so a change shows at the very next pixel stage.
  always_comb begin
    o_frame = FR_FLAP0;
    case (r_state)
      ST_FLY:  o_frame = i_flap_frame;
      ST_SHOT: o_frame = FR_SHOT;
      ST_FALL: o_frame = FR_FALL;
      default: o_frame = FR_FLAP0;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/duck_sprite_ctrl.sv
// Animation sequencer and frame-RAM read arbiter for two ducks: hit test,
// address generation and a 3-stage pixel pipeline around the synchronous RAM.
module duck_sprite_ctrl
  import duck_pkg::*;
#(
  parameter int SPRITE_W   = SPRITE_W_DEF,
  parameter int SPRITE_H   = SPRITE_H_DEF,
  parameter int FLAP_DIV   = 6,
  parameter int SHOT_TICKS = 30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [1:0]  spawn,
  input  logic [1:0]  shot,
  input  logic [1:0]  landed,
  input  logic [9:0]  duck0_x,
  input  logic [9:0]  duck0_y,
  input  logic [9:0]  duck1_x,
  input  logic [9:0]  duck1_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [18:0] sprite_rd_addr,
  output logic [2:0]  sprite_frame,
  input  logic [2:0]  sprite_data,
  output logic [3:0]  duck_state,
  output logic        pixel_on,
  output logic [2:0]  pixel_idx,
  output logic        pixel_duck
);

  localparam int FW = (FLAP_DIV > 1) ? $clog2(FLAP_DIV) : 1;

  logic [FW-1:0] r_flap_cnt;
  logic [1:0]    r_flap_phase;
  frame_t        w_flap_frame;
  duck_state_t   w_state0, w_state1;
  frame_t        w_frame0, w_frame1;

  logic          w_hit0, w_hit1, w_any_hit;
  logic [9:0]    w_dx, w_dy;
  logic [18:0]   w_addr;

  logic          r_s1_valid, r_s1_duck;
  logic [18:0]   r_rd_addr;
  logic [2:0]    r_frame;
  logic          r_s2_valid, r_s2_duck;
  logic          r_pix_on, r_pix_duck;
  logic [2:0]    r_pix_idx;

  // Compared in 11 bits so a sprite near the right edge cannot wrap to column 0.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] scan,
                                   input int unsigned size);
    logic [10:0] lo, hi, s;
    lo = {1'b0, pos};
    hi = lo + 11'(size - 1);
    s  = {1'b0, scan};
    return (s >= lo) && (s <= hi);
  endfunction

  // Shared flap divider: runs on every frame tick regardless of duck states.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_flap_cnt   <= '0;
      r_flap_phase <= 2'd0;
    end else if (frame_tick) begin
      if (r_flap_cnt == FW'(FLAP_DIV - 1)) begin
        r_flap_cnt   <= '0;
        r_flap_phase <= r_flap_phase + 2'd1;
      end else begin
        r_flap_cnt <= r_flap_cnt + FW'(1);
      end
    end else begin
      r_flap_cnt <= r_flap_cnt;
    end
  end

  assign w_flap_frame = flap_frame_of(r_flap_phase);

  duck_fsm #(.SHOT_TICKS(SHOT_TICKS)) u_fsm0 (
    .i_clk        (Clk),
    .i_rst_n      (Reset_n),
    .i_frame_tick (frame_tick),
    .i_spawn      (spawn[0]),
    .i_shot       (shot[0]),
    .i_landed     (landed[0]),
    .i_flap_frame (w_flap_frame),
    .o_state      (w_state0),
    .o_frame      (w_frame0)
  );

  duck_fsm #(.SHOT_TICKS(SHOT_TICKS)) u_fsm1 (
    .i_clk        (Clk),
    .i_rst_n      (Reset_n),
    .i_frame_tick (frame_tick),
    .i_spawn      (spawn[1]),
    .i_shot       (shot[1]),
    .i_landed     (landed[1]),
    .i_flap_frame (w_flap_frame),
    .o_state      (w_state1),
    .o_frame      (w_frame1)
  );

  assign w_hit0 = (w_state0 != ST_IDLE) &&
                  in_span(duck0_x, DrawX, SPRITE_W) && in_span(duck0_y, DrawY, SPRITE_H);
  assign w_hit1 = (w_state1 != ST_IDLE) &&
                  in_span(duck1_x, DrawX, SPRITE_W) && in_span(duck1_y, DrawY, SPRITE_H);
  assign w_any_hit = w_hit0 || w_hit1;

  // Duck 0 always wins the port on overlap, even where its pixel is transparent.
  assign w_dx   = w_hit0 ? (DrawX - duck0_x) : (DrawX - duck1_x);
  assign w_dy   = w_hit0 ? (DrawY - duck0_y) : (DrawY - duck1_y);
  assign w_addr = 19'(w_dy) * 19'(SPRITE_W) + 19'(w_dx);

  // Stage 1: hit, owner, RAM address and frame select.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_duck  <= 1'b0;
      r_rd_addr  <= 19'd0;
      r_frame    <= 3'd0;
    end else begin
      r_s1_valid <= w_any_hit;
      r_s1_duck  <= !w_hit0 && w_hit1;
      r_rd_addr  <= w_any_hit ? w_addr : 19'd0;
      if (w_hit0)      r_frame <= w_frame0;
      else if (w_hit1) r_frame <= w_frame1;
      else             r_frame <= 3'd0;
    end
  end

  // Stage 2: sideband travels alongside the RAM's own output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_duck  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_duck  <= r_s1_duck;
    end
  end

  // Stage 3: palette index 0 is transparent.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pix_on   <= 1'b0;
      r_pix_idx  <= 3'd0;
      r_pix_duck <= 1'b0;
    end else begin
      r_pix_on   <= r_s2_valid && (sprite_data != 3'd0);
      r_pix_idx  <= (r_s2_valid && (sprite_data != 3'd0)) ? sprite_data : 3'd0;
      r_pix_duck <= r_s2_valid ? r_s2_duck : 1'b0;
    end
  end

  assign sprite_rd_addr = r_rd_addr;
  assign sprite_frame   = r_frame;
  assign duck_state     = {w_state1, w_state0};
  assign pixel_on       = r_pix_on;
  assign pixel_idx      = r_pix_idx;
  assign pixel_duck     = r_pix_duck;

endmodule

// File: doc/duck_sprite_ctrl.md
# duck_sprite_ctrl

Animation sequencer and read-port arbiter for the duck sprite frame RAMs. Tracks the life state of two on-screen ducks, picks the animation frame for each, and shares the single synchronous read port of the 20x20, 3-bit-per-pixel frame RAMs between them. For every scanned pixel it returns a palette index and an on flag to the color mapper.

## Interface
- SPRITE_W, 20: sprite width in pixels.
- SPRITE_H, 20: sprite height in pixels; frame RAM depth = SPRITE_W*SPRITE_H = 400.
- FLAP_DIV, 6: frame_tick pulses per flap-frame advance.
- SHOT_TICKS, 30: frame_tick pulses the SHOT pose is held.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (vsync).
- spawn[1:0]  in  2  per-duck spawn request, level sampled each cycle.
- shot[1:0]  in  2  per-duck hit report.
- landed[1:0]  in  2  per-duck "reached ground" report.
- duck0_x, duck0_y, duck1_x, duck1_y  in  10 each  top-left sprite position.
- DrawX, DrawY  in  10 each  current scan pixel.
- sprite_rd_addr  out  19  read address into the frame RAMs, 0..399.
- sprite_frame  out  3  frame select for the external RAM-output mux.
- sprite_data  in  3  RAM output, valid one cycle after the address is registered.
- duck_state[3:0]  out  4  {duck1, duck0} state codes, 2 bits each.
- pixel_on  out  1  opaque duck pixel at the delayed scan position.
- pixel_idx  out  3  palette index (0 when pixel_on = 0).
- pixel_duck  out  1  duck that owns the pixel.

## Operation
- Per-duck FSM with states IDLE=0, FLY=1, SHOT=2, FALL=3.
  - IDLE -> FLY on spawn.
  - FLY -> SHOT on shot; the hold counter loads 0.
  - SHOT -> FALL when the hold counter reaches SHOT_TICKS-1 on a frame_tick.
  - FALL -> IDLE on landed.
  - Inputs that do not apply to the current state are ignored (shot in IDLE/SHOT/FALL, spawn outside IDLE, landed outside FALL).
  - spawn and shot together in IDLE: spawn wins; shot is dropped.
- Shared flap counter: counts frame_tick pulses modulo FLAP_DIV. On wrap, the flap phase advances through 0,1,2,3 and back to 0. Phase to frame mapping: FLAP0, FLAP1, FLAP2, FLAP1.
- Frame per state:
  - FLY: the current flap frame.
  - SHOT: SHOT frame.
  - FALL: FALL frame.
  - IDLE: not drawn.
- Hit test for a non-IDLE duck: x ≤ DrawX ≤ x+SPRITE_W-1 and y ≤ DrawY ≤ y+SPRITE_H-1.
  - Compute in 11 bits so that x+19 cannot wrap past 1023.
- Arbitration: when both ducks hit, duck 0 owns the read port, so duck 0 is drawn in front. No fallback to duck 1 on a transparent duck-0 pixel.
- Address: (DrawY-y)*SPRITE_W + (DrawX-x), zero-extended to 19 bits. It is 0 when there is no hit.
- Transparency: sprite_data == 0 gives pixel_on = 0 and pixel_idx = 0.

## Timing
- Stage 1 (edge 1): hit result, sprite_rd_addr, sprite_frame and owner are registered.
- Stage 2 (edge 2): the RAM registers sprite_data.
- Stage 3 (edge 3): pixel_on, pixel_idx and pixel_duck are registered.
- Total latency is 3 cycles from DrawX/DrawY to pixel outputs, with a fully pipelined throughput of 1 pixel per cycle.
- State transitions take effect on the edge where the input is sampled. A frame change for a pixel applies from the next Stage 1.
- Reset (any time, including mid-SHOT or mid-pipeline) clears, asynchronously:
  - Both FSMs to IDLE; flap counter, flap phase and hold counters to 0.
  - sprite_rd_addr, sprite_frame, pixel_on, pixel_idx, pixel_duck and duck_state to 0.
  - All pipeline valid bits to 0.
- frame_tick coincident with a state change: the hold counter counts only while in SHOT. The flap counter always counts, independent of state.

## Structure
- duck_pkg holds:
  - the duck_state_t enum (IDLE/FLY/SHOT/FALL);
  - the frame_t enum: FLAP0=0, FLAP1=1, FLAP2=2, SHOT=3, FALL=4;
  - the SPRITE_W and SPRITE_H defaults.
- One sub-module, duck_fsm, instantiated twice: a single duck's FSM plus its hold counter, taking the shared flap frame and outputting state and frame_t.
- Hit test, arbitration and the pipeline stay in the top level.

## Test plan
- Reset, then spawn[0] for 1 cycle, then 24 frame_tick pulses with FLAP_DIV=6 -> duck_state[1:0]=1; sprite_frame for duck-0 pixels steps through 0,1,2,1.
- Duck 0 at (100,50), DrawX=119, DrawY=69 -> sprite_rd_addr=399 after 1 cycle; pixel_idx equals the RAM word 3 cycles after DrawX/DrawY; DrawX=120 -> no hit, pixel_on=0.
- Both ducks at (200,200) in FLY, DrawX/DrawY=(205,203) -> pixel_duck=0, sprite_rd_addr=65.
- shot[0] in FLY, then 30 frame_tick pulses -> state 2 with sprite_frame=3 for the whole hold, then 3 with frame 4; landed[0] -> state 0 and pixel_on=0 for all pixels.
- Duck 0 x=1015, DrawX=3 -> no hit; RAM returns 0 inside the box -> pixel_on=0.
- Reset_n low mid-SHOT with the pipeline full -> all outputs 0 immediately; after release the ducks stay IDLE until spawn.
